// File: rtl/mor1kx_tlb_reload_responder_pkg.sv
// Shared types and constants for the TLB-reload responder and its arbiter.
package mor1kx_tlb_reload_responder_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StBus   = 3'd1,
    StRetry = 3'd2,
    StResp  = 3'd3,
    StGap   = 3'd4
  } tlbrl_state_e;

  localparam logic GrantDmmu = 1'b0;
  localparam logic GrantImmu = 1'b1;

  localparam logic [3:0] WbSel = 4'hf;
  localparam logic [2:0] WbCti = 3'b000;
  localparam logic [1:0] WbBte = 2'b00;

endpackage

// File: rtl/mor1kx_rr_arbiter2.sv
// Two-requester round-robin pick; the last_grant register advances only when a response is sent.
module mor1kx_rr_arbiter2
  import mor1kx_tlb_reload_responder_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic dmmu_req,
  input  logic immu_req,
  input  logic advance,
  input  logic served,
  output logic pick_immu,
  output logic last_grant
);

  logic last_grant_q;

  // On a tie the port that was not served last wins.
  always_comb begin
    pick_immu = immu_req && (!dmmu_req || (last_grant_q == GrantDmmu));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= GrantImmu;
    end else if (advance) begin
      last_grant_q <= served;
    end
  end

  assign last_grant = last_grant_q;

endmodule

// File: rtl/mor1kx_tlb_reload_responder.sv
// Serves DMMU/IMMU hardware TLB-reload reads with single Wishbone classic word reads.
module mor1kx_tlb_reload_responder
  import mor1kx_tlb_reload_responder_pkg::*;
#(
  parameter int unsigned OPTION_OPERAND_WIDTH = 32,
  parameter int unsigned TIMEOUT_WIDTH        = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            dmmu_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] dmmu_addr_i,
  output logic                            dmmu_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] dmmu_data_o,
  input  logic                            immu_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] immu_addr_i,
  output logic                            immu_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] immu_data_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] wbm_adr_o,
  output logic                            wbm_cyc_o,
  output logic                            wbm_stb_o,
  output logic                            wbm_we_o,
  output logic [3:0]                      wbm_sel_o,
  output logic [2:0]                      wbm_cti_o,
  output logic [1:0]                      wbm_bte_o,
  input  logic [OPTION_OPERAND_WIDTH-1:0] wbm_dat_i,
  input  logic                            wbm_ack_i,
  input  logic                            wbm_err_i,
  input  logic                            wbm_rty_i,
  output logic                            bus_error_o
);

  localparam int unsigned W = OPTION_OPERAND_WIDTH;
  // Last BUS cycle before giving up: the read is abandoned after 2**TIMEOUT_WIDTH-1 cycles.
  localparam logic [TIMEOUT_WIDTH-1:0] TimeoutLast = TIMEOUT_WIDTH'((1 << TIMEOUT_WIDTH) - 2);

  tlbrl_state_e             state_q;
  logic                     grant_q;
  logic [TIMEOUT_WIDTH-1:0] cnt_q;
  logic [W-1:0]             data_q;
  logic [W-1:0]             adr_q;
  logic                     cyc_q;
  logic                     dmmu_ack_q;
  logic                     immu_ack_q;
  logic                     bus_err_q;

  logic         pick_immu;
  logic         last_grant;
  logic         granted_req;
  logic [W-1:0] sel_addr;

  mor1kx_rr_arbiter2 u_arbiter (
    .clk        (clk),
    .rst        (rst),
    .dmmu_req   (dmmu_req_i),
    .immu_req   (immu_req_i),
    .advance    (state_q == StResp),
    .served     (grant_q),
    .pick_immu  (pick_immu),
    .last_grant (last_grant)
  );

  always_comb begin
    granted_req = (grant_q == GrantImmu) ? immu_req_i : dmmu_req_i;
    sel_addr    = pick_immu ? immu_addr_i : dmmu_addr_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      grant_q    <= GrantDmmu;
      cnt_q      <= '0;
      data_q     <= '0;
      adr_q      <= '0;
      cyc_q      <= 1'b0;
      dmmu_ack_q <= 1'b0;
      immu_ack_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      dmmu_ack_q <= 1'b0;
      immu_ack_q <= 1'b0;
      bus_err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (dmmu_req_i || immu_req_i) begin
            grant_q <= pick_immu;
            adr_q   <= sel_addr & ~W'(3);
            cyc_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= StBus;
          end
        end
        StBus: begin
          if (!granted_req) begin
            // Requester withdrew: abandon quietly.
            cyc_q   <= 1'b0;
            state_q <= StIdle;
          end else if (wbm_err_i || (cnt_q == TimeoutLast)) begin
            cyc_q      <= 1'b0;
            data_q     <= '0;
            bus_err_q  <= 1'b1;
            dmmu_ack_q <= (grant_q == GrantDmmu);
            immu_ack_q <= (grant_q == GrantImmu);
            state_q    <= StResp;
          end else if (wbm_ack_i) begin
            cyc_q      <= 1'b0;
            data_q     <= wbm_dat_i;
            dmmu_ack_q <= (grant_q == GrantDmmu);
            immu_ack_q <= (grant_q == GrantImmu);
            state_q    <= StResp;
          end else if (wbm_rty_i) begin
            cyc_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= StRetry;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRetry: begin
          cnt_q <= '0;
          if (!granted_req) begin
            state_q <= StIdle;
          end else begin
            cyc_q   <= 1'b1;
            state_q <= StBus;
          end
        end
        StResp: state_q <= StGap;
        StGap:  state_q <= StIdle;
        default: begin
          cyc_q   <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign dmmu_ack_o  = dmmu_ack_q;
  assign immu_ack_o  = immu_ack_q;
  assign dmmu_data_o = data_q;
  assign immu_data_o = data_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = 1'b0;
  assign wbm_sel_o   = WbSel;
  assign wbm_cti_o   = WbCti;
  assign wbm_bte_o   = WbBte;
  assign bus_error_o = bus_err_q;

endmodule

// File: tb/tb_mor1kx_tlb_reload_responder.sv
// Directed, table-driven bench for the TLB-reload responder with a small scripted slave.
module tb_mor1kx_tlb_reload_responder;

  localparam int RAck  = 0;
  localparam int RErr  = 1;
  localparam int RNone = 2;
  localparam int RRty  = 3;

  typedef struct {
    bit          is_immu;
    logic [31:0] addr;
    int          reply;
    int          wait_cyc;
    logic [31:0] rdata;
    logic [31:0] exp_adr;
    logic [31:0] exp_data;
    int          exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dmmu_req_i = 1'b0, immu_req_i = 1'b0;
  logic [31:0] dmmu_addr_i = '0, immu_addr_i = '0;
  logic        dmmu_ack_o, immu_ack_o, bus_error_o;
  logic [31:0] dmmu_data_o, immu_data_o, wbm_adr_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack_i = 1'b0, wbm_err_i = 1'b0, wbm_rty_i = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mor1kx_tlb_reload_responder #(
    .OPTION_OPERAND_WIDTH (32),
    .TIMEOUT_WIDTH        (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dmmu_req_i  (dmmu_req_i),
    .dmmu_addr_i (dmmu_addr_i),
    .dmmu_ack_o  (dmmu_ack_o),
    .dmmu_data_o (dmmu_data_o),
    .immu_req_i  (immu_req_i),
    .immu_addr_i (immu_addr_i),
    .immu_ack_o  (immu_ack_o),
    .immu_data_o (immu_data_o),
    .wbm_adr_o   (wbm_adr_o),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_we_o    (wbm_we_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_cti_o   (wbm_cti_o),
    .wbm_bte_o   (wbm_bte_o),
    .wbm_dat_i   (wbm_dat_i),
    .wbm_ack_i   (wbm_ack_i),
    .wbm_err_i   (wbm_err_i),
    .wbm_rty_i   (wbm_rty_i),
    .bus_error_o (bus_error_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_slave();
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_rty_i = 1'b0;
  endtask

  // One read on one port with the slave replying as the vector says.
  task automatic do_read(input vec_t v);
    int  n = 0, cyc_cnt = 0, replied_at = -100, rty_at = -100, errs = 0;
    bit  got = 0, retried = 0;
    logic mine, other;
    if (v.is_immu) begin immu_req_i = 1'b1; immu_addr_i = v.addr; end
    else begin dmmu_req_i = 1'b1; dmmu_addr_i = v.addr; end
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      clear_slave();
      if (dmmu_ack_o && immu_ack_o) chk("both_acks", 32'd1, 32'd0);
      if (bus_error_o) errs++;
      mine  = v.is_immu ? immu_ack_o : dmmu_ack_o;
      other = v.is_immu ? dmmu_ack_o : immu_ack_o;
      if (other) chk("wrong_port_ack", 32'd1, 32'd0);
      if (n == rty_at + 1) chk("retry_gap_cyc", 32'(wbm_cyc_o), 32'd0);
      if (n == rty_at + 2) chk("retry_reissue_cyc", 32'(wbm_cyc_o), 32'd1);
      if (mine) begin
        got = 1;
        chk("ack_data", v.is_immu ? immu_data_o : dmmu_data_o, v.exp_data);
        chk("ack_cyc_low", 32'(wbm_cyc_o), 32'd0);
        if (v.reply == RNone) chk("timeout_cycles", 32'(cyc_cnt), 32'd15);
        else chk("ack_latency", 32'(n), 32'(replied_at + 1));
        if (v.is_immu) immu_req_i = 1'b0; else dmmu_req_i = 1'b0;
      end else if (wbm_cyc_o) begin
        cyc_cnt++;
        chk("bus_adr", wbm_adr_o, v.exp_adr);
        chk("stb_eq_cyc", 32'(wbm_stb_o), 32'd1);
        if (cyc_cnt == v.wait_cyc) begin
          if (v.reply == RAck || (v.reply == RRty && retried)) begin
            wbm_ack_i = 1'b1; wbm_dat_i = v.rdata; replied_at = n;
          end else if (v.reply == RErr) begin
            wbm_err_i = 1'b1; wbm_dat_i = 32'hFFFF_FFFF; replied_at = n;
          end else if (v.reply == RRty) begin
            wbm_rty_i = 1'b1; retried = 1; rty_at = n; cyc_cnt = 0;
          end
        end
      end
    end
    chk("ack_seen", 32'(got), 32'd1);
    repeat (3) begin
      @(negedge clk);
      if (bus_error_o) errs++;
      if (dmmu_ack_o || immu_ack_o) chk("extra_ack", 32'd1, 32'd0);
    end
    chk("bus_error_pulses", 32'(errs), 32'(v.exp_err));
  endtask

  vec_t vecs[6];

  initial begin
    int order[3];
    int nack, n, spurious;
    logic [31:0] exp;

    vecs[0] = '{0, 32'h0000_1006, RAck,  2, 32'hABCD_E000, 32'h0000_1004, 32'hABCD_E000, 0};
    vecs[1] = '{1, 32'h8000_0003, RAck,  1, 32'h1234_5678, 32'h8000_0000, 32'h1234_5678, 0};
    vecs[2] = '{0, 32'hFFFF_FFFF, RErr,  3, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000, 1};
    vecs[3] = '{1, 32'h0000_2008, RNone, 0, 32'h0000_0000, 32'h0000_2008, 32'h0000_0000, 1};
    vecs[4] = '{0, 32'h0000_300A, RRty,  2, 32'h55AA_0FF0, 32'h0000_3008, 32'h55AA_0FF0, 0};
    vecs[5] = '{1, 32'h4444_4445, RAck,  5, 32'hDEAD_BEEF, 32'h4444_4444, 32'hDEAD_BEEF, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
    chk("rst_stb", 32'(wbm_stb_o), 32'd0);
    chk("rst_adr", wbm_adr_o, 32'd0);
    chk("rst_acks", {30'd0, dmmu_ack_o, immu_ack_o}, 32'd0);
    chk("rst_data", dmmu_data_o | immu_data_o, 32'd0);
    chk("rst_bus_error", 32'(bus_error_o), 32'd0);
    chk("const_bus_attrs", {20'd0, wbm_we_o, wbm_sel_o, wbm_cti_o, wbm_bte_o, 2'b00},
        {20'd0, 1'b0, 4'hf, 3'b000, 2'b00, 2'b00});

    // Round robin from reset with both requests held: DMMU, IMMU, DMMU.
    dmmu_addr_i = 32'h0000_A001;
    immu_addr_i = 32'h0000_B002;
    dmmu_req_i  = 1'b1;
    immu_req_i  = 1'b1;
    nack = 0;
    n    = 0;
    while (nack < 3 && n < 60) begin
      @(negedge clk);
      n++;
      clear_slave();
      if (dmmu_ack_o && immu_ack_o) chk("rr_both_acks", 32'd1, 32'd0);
      if (dmmu_ack_o || immu_ack_o) begin
        order[nack] = immu_ack_o ? 1 : 0;
        exp = (immu_ack_o ? 32'h0000_B000 : 32'h0000_A000) ^ 32'h0F0F_0F0F;
        chk("rr_data", immu_ack_o ? immu_data_o : dmmu_data_o, exp);
        nack++;
      end else if (wbm_cyc_o) begin
        wbm_ack_i = 1'b1;
        wbm_dat_i = wbm_adr_o ^ 32'h0F0F_0F0F;
      end
    end
    chk("rr_count", 32'(nack), 32'd3);
    chk("rr_first_dmmu", 32'(order[0]), 32'd0);
    chk("rr_second_immu", 32'(order[1]), 32'd1);
    chk("rr_third_dmmu", 32'(order[2]), 32'd0);
    dmmu_req_i = 1'b0;
    immu_req_i = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      do_read(vecs[i]);
    end

    // Requester withdraws mid-read: cyc drops next cycle, no ack, no error.
    dmmu_addr_i = 32'h0000_5000;
    dmmu_req_i  = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!wbm_cyc_o && n < 10);
    chk("abort_cyc_started", 32'(wbm_cyc_o), 32'd1);
    @(negedge clk);
    dmmu_req_i = 1'b0;
    @(negedge clk);
    chk("abort_cyc_dropped", 32'(wbm_cyc_o), 32'd0);
    spurious = 0;
    repeat (6) begin
      @(negedge clk);
      if (dmmu_ack_o || immu_ack_o || bus_error_o || wbm_cyc_o) spurious++;
    end
    chk("abort_quiet", 32'(spurious), 32'd0);

    // Reset mid-read clears everything in the next cycle.
    dmmu_addr_i = 32'h0000_6000;
    dmmu_req_i  = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!wbm_cyc_o && n < 10);
    chk("mid_rst_cyc_started", 32'(wbm_cyc_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_cyc", 32'(wbm_cyc_o), 32'd0);
    chk("mid_rst_stb", 32'(wbm_stb_o), 32'd0);
    chk("mid_rst_adr", wbm_adr_o, 32'd0);
    chk("mid_rst_acks", {30'd0, dmmu_ack_o, immu_ack_o}, 32'd0);
    chk("mid_rst_data", dmmu_data_o | immu_data_o, 32'd0);
    chk("mid_rst_bus_error", 32'(bus_error_o), 32'd0);
    dmmu_req_i = 1'b0;
    rst = 1'b0;
    spurious = 0;
    repeat (4) begin
      @(negedge clk);
      if (dmmu_ack_o || immu_ack_o || wbm_cyc_o) spurious++;
    end
    chk("post_rst_quiet", 32'(spurious), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
